// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

    // Width of one adder slice in bits
    localparam int unsigned SLICE_W = 4;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slices needed to cover an operand of the given width
    function automatic int unsigned slice_count(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage : nibble_serial_adder_pkg

// File: rtl/nibble_adder_slice.sv
// One 4-bit add slice with carry in; also exposes the carry into its top bit.
module nibble_adder_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c2
);

    logic [SLICE_W:0]   full;
    logic [SLICE_W-1:0] low;

    // Full 5-bit add so the carry is taken before any truncation; the 3-bit
    // partial add gives the carry into bit 3, needed for signed overflow.
    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
        low  = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin};
        sum  = full[SLICE_W-1:0];
        cout = full[SLICE_W];
        c2   = low[SLICE_W-1];
    end

endmodule : nibble_adder_slice

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit slice per cycle, LSB first,
// with valid/ready handshakes on the operand and result sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NIBBLES = slice_count(WIDTH);
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
    logic               c_sl, c2_sl;
    logic               accept;
    logic               last;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    assign accept = in_valid && in_ready;
    assign last   = (idx_q == IDX_W'(NIBBLES - 1));

    // Select the operand slices addressed by the current index
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sl = a_q[i*SLICE_W +: SLICE_W];
                b_sl = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    nibble_adder_slice u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_q),
        .sum  (s_sl),
        .cout (c_sl),
        .c2   (c2_sl)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*SLICE_W +: SLICE_W] = s_sl;
                    end
                end
                carry_d = c_sl;
                if (last) begin
                    cout_d  = c_sl;
                    ovf_d   = c_sl ^ c2_sl;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand holding registers; contents are irrelevant after reset
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[9];

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait for its result; operands are scrambled
    // right after accept to show they were latched.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic ci, output logic [WIDTH-1:0] s,
                         output logic co, output logic ov, output int lat);
        int n;
        a = av; b = bv; cin = ci; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        s = sum; co = cout; ov = ovf;
        if (out_ready) step();
    endtask

    initial begin
        logic [WIDTH-1:0] s;
        logic             co, ov;
        int               lat;
        int               acc_cyc[2];
        int               n_acc, n_res, n;
        logic [WIDTH-1:0] r_sum[2];
        logic             r_cout[2];
        logic             stale;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[5] = '{16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[8] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b1; a = 16'h0101; b = 16'h0202; cin = 1'b0; out_ready = 1'b1;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        step();

        // Table-driven vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(NIBBLES));
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].exp_cout));
            check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].exp_ovf));
        end

        // Backpressure in DONE with an ignored in_valid pulse
        out_ready = 1'b0;
        do_op(16'h1234, 16'h4321, 1'b0, s, co, ov, lat);
        check("bp_first_sum", 32'(s), 32'h5555);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; a = 16'h1111; b = 16'h1111; cin = 1'b0;
            #1;
            check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd0);
            step();
            check($sformatf("bp_hold_%0d", k), 32'({out_valid, cout, ovf, sum}), 32'({1'b1, 1'b0, 1'b0, 16'h5555}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_idle", 32'({busy, out_valid}), 32'd0);
        check("bp_sum_kept", 32'(sum), 32'h5555);
        do_op(16'h1111, 16'h1111, 1'b0, s, co, ov, lat);
        check("bp_second_sum", 32'(s), 32'h2222);
        check("bp_second_latency", 32'(lat), 32'(NIBBLES));

        // Reset on the second RUN cycle aborts the operation
        a = 16'hABCD; b = 16'h1234; cin = 1'b0; in_valid = 1'b1;
        #1;
        check("abort_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("abort_state", 32'({busy, out_valid}), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_in_ready_in_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        stale = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (out_valid || busy) stale = 1'b1;
        end
        check("abort_no_stale", 32'(stale), 32'd0);

        // Back-to-back with in_valid held high
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        n_acc = 0; n_res = 0; n = 0;
        while ((n_acc < 2 || n_res < 2) && n < 40) begin
            if (in_valid && in_ready) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (out_valid && out_ready && n_res < 2) begin
                r_sum[n_res] = sum;
                r_cout[n_res] = cout;
                n_res++;
            end
            step();
            if (n_acc == 1) begin
                a = 16'hF000; b = 16'h1000;
            end else if (n_acc == 2) begin
                in_valid = 1'b0;
            end
            n++;
        end
        if (n_acc < 2 || n_res < 2) begin
            check("b2b_timeout", 32'(n_acc + n_res), 32'd4);
        end else begin
            check("b2b_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'(NIBBLES + 2));
            check("b2b_sum0", 32'(r_sum[0]), 32'h0100);
            check("b2b_cout0", 32'(r_cout[0]), 32'd0);
            check("b2b_sum1", 32'(r_sum[1]), 32'h0000);
            check("b2b_cout1", 32'(r_cout[1]), 32'd1);
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nibble_serial_adder

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that computes A + B + cin one 4-bit slice per cycle, LSB slice first.
- A registered carry chains the slices, so one 4-bit adder slice serves any operand width.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area against a flat WIDTH-bit adder.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived slice count; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, cin are valid this cycle
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry in to the LSB slice
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result bits [WIDTH-1:0]
- cout  output  1  carry out of the MSB (unsigned overflow)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- busy  output  1  high in RUN or DONE

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset: when rst=1 at a clock edge:
  - state goes to IDLE.
  - sum, cout, ovf, out_valid, the slice index and the carry register all go to 0.
  - Operand registers are don't-care.
  - Reset mid-RUN or mid-DONE aborts the operation. No out_valid is produced for it.
- Output decodes (combinational from state):
  - in_ready = (state==IDLE) and not rst.
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE:
  - On in_valid && in_ready, latch a, b; load carry register with cin; set idx=0; clear sum to 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Compute {c,s} = a[4*idx+3:4*idx] + b[4*idx+3:4*idx] + carry, as 5-bit arithmetic with no truncation before the carry is taken.
  - Write s into sum[4*idx+3:4*idx] and set carry <= c.
  - If idx == NIBBLES-1:
    - cout <= c.
    - ovf <= c XOR (carry out of bit WIDTH-2 within the top slice). Computing it needs the 3-bit partial add of the top slice's low bits plus the incoming carry.
    - Go to DONE.
  - Otherwise idx <= idx+1.
- DONE:
  - Hold sum, cout and ovf stable while out_valid=1 && out_ready=0.
  - On out_ready=1, go to IDLE. sum, cout and ovf keep their values until the next accept.
- Latency: operands accepted at edge T; out_valid goes high after edge T+NIBBLES (4 cycles for WIDTH=16) and stays high until the handshake.
- Throughput: one operation per NIBBLES+2 cycles minimum. A new accept cannot happen in the same cycle the result is consumed.
- in_valid asserted while busy is ignored: in_ready=0 and no state change. The upstream stage holds its operands.
- Changes on a or b inputs after the accept do not affect the in-flight result, because the operands are latched.
- Wrap-around: the carry out of the MSB never feeds back into the LSB; it appears only on cout.
- WIDTH=4: RUN lasts exactly one cycle.
- Simultaneous rst and in_valid: rst wins, nothing is accepted.

Decomposition:
- Shared package holds:
  - The FSM state enum (IDLE, RUN, DONE) with 2-bit encoding.
  - The constant SLICE_W = 4.
  - A function returning the slice count for a given width.
- Natural sub-module: nibble_adder_slice.
  - Combinational, 4-bit a/b, 1-bit cin; outputs 4-bit sum, cout, and the carry out of bit 2 (used for ovf).
  - Instantiated once, with operand slices selected by idx.
- The top level holds the FSM, index counter, carry register, operand registers and result register.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid high 4 cycles after accept; sum=0x5555, cout=0, ovf=0.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0; carry ripples through all 4 slices.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum, cout, ovf and out_valid stable. in_valid pulsed during that time with a=0x1111 is not accepted (in_ready=0). Release out_ready -> IDLE, then accept 0x1111.
- Reset mid-RUN: rst=1 on the 2nd RUN cycle of a=0xABCD, b=0x1234 -> next cycle state IDLE, out_valid=0, sum=0, in_ready=1 once rst is low. No stale result appears later.
- Back-to-back: two transactions with in_valid held high and out_ready=1 -> second accept occurs exactly NIBBLES+2 cycles after the first, and both sums are correct (e.g. 0x00FF+0x0001=0x0100, then 0xF000+0x1000=0x0000 with cout=1).
